// File: rtl/move_seq_pkg.sv
// Shared types for the sprite move sequencer: jump FSM encoding and button bit positions.
package move_seq_pkg;

  typedef enum logic [1:0] {
    ST_GROUND   = 2'd0,
    ST_CHARGE   = 2'd1,
    ST_LAUNCH   = 2'd2,
    ST_AIRBORNE = 2'd3
  } jump_state_e;

  localparam int CTRL_RUN  = 0;
  localparam int CTRL_JUMP = 1;

endpackage

// File: rtl/move_sequencer_sat_ramp.sv
// Saturating step counter: value grows by one every STEP_FRAMES enabled steps, capped at MAX_VAL.
module sat_ramp #(
  parameter int STEP_FRAMES = 2,
  parameter int INIT_VAL    = 0,
  parameter int LOAD_VAL    = 0,
  parameter int MAX_VAL     = 1
) (
  input  logic        i_clk_pix,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic        i_step,
  output logic [15:0] o_value
);

  localparam logic [15:0] LAST_CNT = 16'(STEP_FRAMES - 1);
  localparam logic [15:0] INIT_V   = 16'(INIT_VAL);
  localparam logic [15:0] LOAD_V   = 16'(LOAD_VAL);
  localparam logic [15:0] MAX_V    = 16'(MAX_VAL);

  logic [15:0] step_cnt;

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n || i_clr) begin
      step_cnt <= '0;
      o_value  <= INIT_V;
    end else if (i_load) begin
      step_cnt <= '0;
      o_value  <= LOAD_V;
    end else if (i_step) begin
      // compare before increment so the value never passes MAX_V
      if (step_cnt >= LAST_CNT) begin
        step_cnt <= '0;
        if (o_value < MAX_V) o_value <= o_value + 16'd1;
      end else begin
        step_cnt <= step_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Frame-rate jump/run controller for the sprite position block.
// Optional jump buffering on landing is enabled by defining MOVE_SEQ_JUMP_BUFFER_EN.
//
// state    | meaning
// GROUND   | on the floor, waiting for a fresh jump press
// CHARGE   | jump held, height ramping up
// LAUNCH   | jump requested, waiting for the position block to go airborne
// AIRBORNE | in the air, height frozen until landing
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter int JUMP_MIN      = 8,
  parameter int JUMP_MAX      = 20,
  parameter int CHARGE_FRAMES = 2,
  parameter int RUN_MIN       = 1,
  parameter int RUN_MAX       = 6,
  parameter int ACCEL_FRAMES  = 4,
  parameter int BUF_FRAMES    = 6
) (
  input  logic        i_clk_pix,
  input  logic        i_rst_n,
  input  logic        i_frame,
  input  logic [5:0]  i_ctrl,
  input  logic        i_jumping,
  output logic        o_jump,
  output logic [15:0] o_jump_height,
  output logic        o_run,
  output logic [15:0] o_run_speed,
  output logic [1:0]  o_state
);

  localparam logic [15:0] JUMP_MAX_V = 16'(JUMP_MAX);

  jump_state_e state, state_nxt;
  logic jmp_prev, jmp_btn, run_btn, jmp_rise;
  logic h_load, h_step, buf_hit;
  logic run_load, run_step, run_clr;
  logic unused_ctrl;

  assign jmp_btn     = i_ctrl[CTRL_JUMP];
  assign run_btn     = i_ctrl[CTRL_RUN];
  assign jmp_rise    = jmp_btn & ~jmp_prev;
  assign unused_ctrl = ^i_ctrl[5:2];

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      jmp_prev <= 1'b0;
      state    <= ST_GROUND;
      o_jump   <= 1'b0;
      o_run    <= 1'b0;
    end else begin
      if (i_frame) begin
        jmp_prev <= jmp_btn;
        o_run    <= run_btn;
      end
      state  <= state_nxt;
      o_jump <= (state_nxt == ST_LAUNCH);
    end
  end

`ifdef MOVE_SEQ_JUMP_BUFFER_EN
  localparam logic [15:0] BUF_LOAD = 16'(BUF_FRAMES);
  logic [15:0] buf_cnt;

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n || h_load) begin
      buf_cnt <= '0;
    end else if (i_frame) begin
      if (state == ST_AIRBORNE && jmp_rise) buf_cnt <= BUF_LOAD;
      else if (buf_cnt != '0)               buf_cnt <= buf_cnt - 16'd1;
    end
  end

  assign buf_hit = (buf_cnt != '0) && jmp_btn;
`else
  logic [15:0] unused_buf_frames;
  assign unused_buf_frames = 16'(BUF_FRAMES);
  assign buf_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    h_load    = 1'b0;
    h_step    = 1'b0;
    case (state)
      ST_GROUND: begin
        if (i_frame && jmp_rise && !i_jumping) begin
          state_nxt = ST_CHARGE;
          h_load    = 1'b1;
        end
      end
      ST_CHARGE: begin
        if (i_frame) begin
          if (!jmp_btn || o_jump_height == JUMP_MAX_V) state_nxt = ST_LAUNCH;
          else                                          h_step    = 1'b1;
        end
      end
      // launch is tracked every clock so the request drops as soon as the sprite leaves the floor
      ST_LAUNCH: begin
        if (i_jumping) state_nxt = ST_AIRBORNE;
      end
      ST_AIRBORNE: begin
        if (i_frame && !i_jumping) begin
          if (buf_hit) begin
            state_nxt = ST_CHARGE;
            h_load    = 1'b1;
          end else begin
            state_nxt = ST_GROUND;
          end
        end
      end
      default: state_nxt = ST_GROUND;
    endcase
  end

  assign o_state = state;

  assign run_clr  = i_frame & ~run_btn;
  assign run_load = i_frame & run_btn & ~o_run;
  assign run_step = i_frame & run_btn & o_run;

  sat_ramp #(
    .STEP_FRAMES (CHARGE_FRAMES),
    .INIT_VAL    (JUMP_MIN),
    .LOAD_VAL    (JUMP_MIN),
    .MAX_VAL     (JUMP_MAX)
  ) u_height (
    .i_clk_pix (i_clk_pix),
    .i_rst_n   (i_rst_n),
    .i_clr     (1'b0),
    .i_load    (h_load),
    .i_step    (h_step),
    .o_value   (o_jump_height)
  );

  sat_ramp #(
    .STEP_FRAMES (ACCEL_FRAMES),
    .INIT_VAL    (0),
    .LOAD_VAL    (RUN_MIN),
    .MAX_VAL     (RUN_MAX)
  ) u_speed (
    .i_clk_pix (i_clk_pix),
    .i_rst_n   (i_rst_n),
    .i_clr     (run_clr),
    .i_load    (run_load),
    .i_step    (run_step),
    .o_value   (o_run_speed)
  );

endmodule
